// File: rtl/qpu_exu_bjp_resolver_pkg.sv
// ============================================================================
// qpu_exu_bjp_resolver_pkg : branch op encodings and result-entry layout
// Revision: 1.0
// ============================================================================
`default_nettype none

package qpu_exu_bjp_resolver_pkg;

  localparam int DEFAULT_XLEN = 32;

  localparam logic [2:0] BJP_OP_EQ = 3'd0;
  localparam logic [2:0] BJP_OP_NE = 3'd1;
  localparam logic [2:0] BJP_OP_LT = 3'd2;
  localparam logic [2:0] BJP_OP_GE = 3'd3;
  localparam logic [2:0] BJP_OP_GT = 3'd4;
  localparam logic [2:0] BJP_OP_LE = 3'd5;

  // Entry layout: flags in the low bits, tag above them.
  localparam int ENT_ILL     = 0;
  localparam int ENT_RSLV    = 1;
  localparam int ENT_PRDT    = 2;
  localparam int ENT_TAG_LSB = 3;
  localparam int ENT_FLAGS_W = 3;

endpackage

`default_nettype wire

// File: rtl/qpu_exu_bjp_resolver_fifo.sv
// ============================================================================
// qpu_bjp_res_fifo : generic DEPTH x W synchronous FIFO with flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module qpu_bjp_res_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/qpu_exu_bjp_resolver.sv
// ============================================================================
// qpu_exu_bjp_resolver : branch compare + in-order result queue toward commit
// Optional: QPU_BJP_PERF_CNT_EN adds saturating branch/mispredict counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module qpu_exu_bjp_resolver
  import qpu_exu_bjp_resolver_pkg::*;
#(
  parameter int XLEN  = DEFAULT_XLEN,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
`ifdef QPU_BJP_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bjp_i_valid,
  output logic             bjp_i_ready,
  input  logic [XLEN-1:0]  bjp_i_rs1,
  input  logic [XLEN-1:0]  bjp_i_rs2,
  input  logic [2:0]       bjp_i_op,
  input  logic             bjp_i_unsigned,
  input  logic             bjp_i_bprdt,
  input  logic [TAG_W-1:0] bjp_i_tag,
  input  logic             bjp_i_flush,
  output logic             bjp_o_valid,
  input  logic             bjp_o_ready,
  output logic             bjp_o_cmt_prdt,
  output logic             bjp_o_cmt_rslv,
  output logic             bjp_o_cmt_mispred,
  output logic [TAG_W-1:0] bjp_o_tag,
  output logic             bjp_o_illegal
`ifdef QPU_BJP_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] bjp_o_cnt_br,
  output logic [CNT_W-1:0] bjp_o_cnt_mis
`endif
);

  localparam int ENT_W = TAG_W + ENT_FLAGS_W;

  logic             w_eq, w_lt_s, w_lt_u, w_lt;
  logic             w_rslv, w_ill;
  logic             w_push, w_pop, w_pop_eff;
  logic             w_full, w_empty;
  logic [ENT_W-1:0] w_wdata, w_rdata, w_head;

  assign w_eq   = (bjp_i_rs1 == bjp_i_rs2);
  assign w_lt_s = ($signed(bjp_i_rs1) < $signed(bjp_i_rs2));
  assign w_lt_u = (bjp_i_rs1 < bjp_i_rs2);
  assign w_lt   = bjp_i_unsigned ? w_lt_u : w_lt_s;

  always_comb begin
    w_rslv = 1'b0;
    w_ill  = 1'b0;
    case (bjp_i_op)
      BJP_OP_EQ: w_rslv = w_eq;
      BJP_OP_NE: w_rslv = !w_eq;
      BJP_OP_LT: w_rslv = w_lt;
      BJP_OP_GE: w_rslv = !w_lt;
      BJP_OP_GT: w_rslv = !w_lt && !w_eq;
      BJP_OP_LE: w_rslv = w_lt || w_eq;
      default:   w_ill  = 1'b1;
    endcase
  end

  assign w_wdata   = {bjp_i_tag, bjp_i_bprdt, w_rslv, w_ill};
  assign bjp_i_ready = !w_full;
  assign w_push    = bjp_i_valid && !w_full && !bjp_i_flush;
  assign w_pop     = bjp_o_valid && bjp_o_ready;
  assign w_pop_eff = w_pop && !bjp_i_flush;

  qpu_bjp_res_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (bjp_i_flush),
    .push_i  (w_push),
    .wdata_i (w_wdata),
    .pop_i   (w_pop_eff),
    .rdata_o (w_rdata),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Masking keeps outputs at zero while empty, since storage is not reset.
  assign w_head            = w_rdata & {ENT_W{!w_empty}};
  assign bjp_o_valid       = !w_empty;
  assign bjp_o_cmt_prdt    = w_head[ENT_PRDT];
  assign bjp_o_cmt_rslv    = w_head[ENT_RSLV];
  assign bjp_o_cmt_mispred = w_head[ENT_PRDT] ^ w_head[ENT_RSLV];
  assign bjp_o_illegal     = w_head[ENT_ILL];
  assign bjp_o_tag         = w_head[ENT_TAG_LSB +: TAG_W];

`ifdef QPU_BJP_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_br_q, cnt_mis_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_br_q  <= '0;
      cnt_mis_q <= '0;
    end else if (w_pop_eff) begin
      if (cnt_br_q != '1) cnt_br_q <= cnt_br_q + CNT_W'(1);
      if (bjp_o_cmt_mispred && (cnt_mis_q != '1)) cnt_mis_q <= cnt_mis_q + CNT_W'(1);
    end
  end

  assign bjp_o_cnt_br  = cnt_br_q;
  assign bjp_o_cnt_mis = cnt_mis_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_qpu_exu_bjp_resolver.sv
// ============================================================================
// tb_qpu_exu_bjp_resolver : directed self-checking bench for the BJP resolver
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_qpu_exu_bjp_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_ready;
  logic [31:0] rs1, rs2;
  logic [2:0]  op;
  logic        uns, bprdt, flush;
  logic [3:0]  tag;
  logic        o_valid, o_ready;
  logic        o_prdt, o_rslv, o_mis, o_ill;
  logic [3:0]  o_tag;
`ifdef QPU_BJP_PERF_CNT_EN
  logic [1:0]  cnt_br, cnt_mis;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  qpu_exu_bjp_resolver #(
    .XLEN  (32),
    .DEPTH (2),
    .TAG_W (4)
`ifdef QPU_BJP_PERF_CNT_EN
    , .CNT_W (2)
`endif
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .bjp_i_valid       (i_valid),
    .bjp_i_ready       (i_ready),
    .bjp_i_rs1         (rs1),
    .bjp_i_rs2         (rs2),
    .bjp_i_op          (op),
    .bjp_i_unsigned    (uns),
    .bjp_i_bprdt       (bprdt),
    .bjp_i_tag         (tag),
    .bjp_i_flush       (flush),
    .bjp_o_valid       (o_valid),
    .bjp_o_ready       (o_ready),
    .bjp_o_cmt_prdt    (o_prdt),
    .bjp_o_cmt_rslv    (o_rslv),
    .bjp_o_cmt_mispred (o_mis),
    .bjp_o_tag         (o_tag),
    .bjp_o_illegal     (o_ill)
`ifdef QPU_BJP_PERF_CNT_EN
    ,
    .bjp_o_cnt_br      (cnt_br),
    .bjp_o_cnt_mis     (cnt_mis)
`endif
  );

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  // Advance one clock; sampling happens 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] o, input logic u, input logic p, input logic [3:0] t);
    i_valid = v; rs1 = a; rs2 = b; op = o; uns = u; bprdt = p; tag = t;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; o_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 3'd0, 1'b0, 1'b0, 4'd0);

    // Reset and idle
    step(); step();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(i_ready), 32'd1);
    check("rst_outs", {27'd0, o_prdt, o_rslv, o_mis, o_ill, 1'b0}, 32'd0);
    check("rst_tag", 32'(o_tag), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle_valid", 32'(o_valid), 32'd0);

    // Signed LT: -1 < 1 taken, predicted not-taken -> mispredict
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0, 1'b0, 4'd1);
    step();
    check("slt_valid", 32'(o_valid), 32'd1);
    check("slt_rslv", 32'(o_rslv), 32'd1);
    check("slt_mis", 32'(o_mis), 32'd1);
    check("slt_tag", 32'(o_tag), 32'd1);
    // Unsigned LT: 0xFFFFFFFF < 1 false; pop previous while pushing
    o_ready = 1'b1;
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd2, 1'b1, 1'b0, 4'd2);
    step();
    check("ult_rslv", 32'(o_rslv), 32'd0);
    check("ult_mis", 32'(o_mis), 32'd0);
    check("ult_tag", 32'(o_tag), 32'd2);
    // Signed GT: 5 > -3, predicted taken
    drive(1'b1, 32'd5, 32'hFFFF_FFFD, 3'd4, 1'b0, 1'b1, 4'd3);
    step();
    check("sgt_rslv", 32'(o_rslv), 32'd1);
    check("sgt_mis", 32'(o_mis), 32'd0);
    // Reserved op 6, predicted taken -> illegal, rslv=0, mispredict
    drive(1'b1, 32'd7, 32'd7, 3'd6, 1'b0, 1'b1, 4'd4);
    step();
    check("rsv_ill", 32'(o_ill), 32'd1);
    check("rsv_rslv", 32'(o_rslv), 32'd0);
    check("rsv_mis", 32'(o_mis), 32'd1);
    // Unsigned LE with equal operands
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 3'd5, 1'b1, 1'b0, 4'd5);
    step();
    check("ule_rslv", 32'(o_rslv), 32'd1);
    check("ule_ill", 32'(o_ill), 32'd0);
    i_valid = 1'b0;
    step();
    check("drain_valid", 32'(o_valid), 32'd0);
    check("drain_tag", 32'(o_tag), 32'd0);

    // Back-to-back: EQ taken, prdt alternates so mispred = ~tag[0]
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h1234, 32'h1234, 3'd0, 1'b0, i[0], 4'(i));
      check("b2b_ready", 32'(i_ready), 32'd1);
      step();
      check("b2b_valid", 32'(o_valid), 32'd1);
      check("b2b_tag", 32'(o_tag), 32'(i));
      check("b2b_mis", 32'(o_mis), 32'(!i[0]));
    end
    i_valid = 1'b0;
    step();
    check("b2b_empty", 32'(o_valid), 32'd0);

    // Backpressure: two accepted, third refused until space frees
    o_ready = 1'b0;
    drive(1'b1, 32'd1, 32'd2, 3'd1, 1'b0, 1'b1, 4'd10);
    step();
    drive(1'b1, 32'd1, 32'd2, 3'd1, 1'b0, 1'b1, 4'd11);
    check("bp_ready2", 32'(i_ready), 32'd1);
    step();
    drive(1'b1, 32'd1, 32'd2, 3'd1, 1'b0, 1'b1, 4'd12);
    check("bp_ready3", 32'(i_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_tag", 32'(o_tag), 32'd10);
      check("bp_hold_ready", 32'(i_ready), 32'd0);
    end
    o_ready = 1'b1;
    step();
    check("bp_pop1_tag", 32'(o_tag), 32'd11);
    check("bp_pop1_ready", 32'(i_ready), 32'd1);
    step();
    check("bp_pop2_tag", 32'(o_tag), 32'd12);
    i_valid = 1'b0;
    step();
    check("bp_empty", 32'(o_valid), 32'd0);

    // Flush with a full queue and a valid input in the same cycle
    o_ready = 1'b0;
    drive(1'b1, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 4'd4);
    step();
    drive(1'b1, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 4'd5);
    step();
    check("fl_pre_tag", 32'(o_tag), 32'd4);
    drive(1'b1, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 4'd6);
    flush = 1'b1; o_ready = 1'b1;
    step();
    flush = 1'b0; i_valid = 1'b0;
    check("fl_valid", 32'(o_valid), 32'd0);
    check("fl_ready", 32'(i_ready), 32'd1);
    step(); step();
    check("fl_later_valid", 32'(o_valid), 32'd0);

    // Reset while an entry is queued
    o_ready = 1'b0;
    drive(1'b1, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 4'd9);
    step();
    check("mr_pre_valid", 32'(o_valid), 32'd1);
    i_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("mr_valid", 32'(o_valid), 32'd0);

`ifdef QPU_BJP_PERF_CNT_EN
    check("pc_rst_br", 32'(cnt_br), 32'd0);
    check("pc_rst_mis", 32'(cnt_mis), 32'd0);
    // Five EQ-taken branches; only the third is predicted taken
    o_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'd3, 32'd3, 3'd0, 1'b0, (i == 2), 4'(i));
      step();
    end
    i_valid = 1'b0;
    step();
    check("pc_br_sat", 32'(cnt_br), 32'd3);
    check("pc_mis_sat", 32'(cnt_mis), 32'd3);
    o_ready = 1'b0;
    drive(1'b1, 32'd3, 32'd3, 3'd0, 1'b0, 1'b0, 4'd7);
    step();
    i_valid = 1'b0; flush = 1'b1; o_ready = 1'b1;
    step();
    flush = 1'b0;
    check("pc_fl_br", 32'(cnt_br), 32'd3);
    check("pc_fl_mis", 32'(cnt_mis), 32'd3);
    check("pc_fl_valid", 32'(o_valid), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qpu_exu_bjp_resolver.md
Name: qpu_exu_bjp_resolver

Overview:
Parametrised successor to the single-cycle branch commit path. It resolves QPU conditional branches with its own signed/unsigned comparator and no longer borrows the ALU datapath. Each result (predicted, resolved, mispredict, tag) is buffered in a DEPTH-entry in-order queue toward commit, so execute and commit are decoupled. The block sits in EXU between dispatch and the commit/flush logic.

Parameters:
XLEN, 32, operand width in bits (≥2)
DEPTH, 2, result queue entries (≥1; DEPTH=2 sustains 1 branch/cycle)
TAG_W, 4, instruction tag width carried through
CNT_W, 16, performance counter width (used only with the optional feature)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous, active-low reset
bjp_i_valid  in  1  request valid
bjp_i_ready  out  1  request ready
bjp_i_rs1  in  XLEN  operand 1
bjp_i_rs2  in  XLEN  operand 2
bjp_i_op  in  3  0=EQ 1=NE 2=LT 3=GE 4=GT 5=LE; 6,7 reserved
bjp_i_unsigned  in  1  1: unsigned compare for LT/GE/GT/LE
bjp_i_bprdt  in  1  predicted taken
bjp_i_tag  in  TAG_W  instruction tag
bjp_i_flush  in  1  kill all queued results
bjp_o_valid  out  1  result valid
bjp_o_ready  in  1  commit ready
bjp_o_cmt_prdt  out  1  predicted taken (echo)
bjp_o_cmt_rslv  out  1  resolved taken
bjp_o_cmt_mispred  out  1  prdt XOR rslv
bjp_o_tag  out  TAG_W  tag of head entry
bjp_o_illegal  out  1  head entry had a reserved op

Behaviour:
- Reset (rst_n=0 at clk edge): queue empty, wr/rd pointers 0, bjp_o_valid=0. Data outputs read as 0 while empty. Reset mid-operation discards all entries.
- Compare: combinational on the input. Signed mode compares two's-complement XLEN values; unsigned mode compares zero-extended values. EQ/NE ignore bjp_i_unsigned. Reserved op: rslv=0, illegal=1.
- Push when bjp_i_valid & bjp_i_ready & !bjp_i_flush. bjp_i_ready = (count < DEPTH). It does not depend on bjp_o_ready, so a pop and push cannot be combined in the same cycle when the queue is full.
- Pop when bjp_o_valid & bjp_o_ready. bjp_o_valid = (count != 0). Outputs drive the head entry directly from registers.
- Latency: a branch accepted in cycle N is visible on the output in cycle N+1 at the earliest. Results leave strictly in acceptance order.
- Simultaneous push and pop (not full): count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- Flush: next cycle count=0 and pointers=0. An input presented in the flush cycle is not accepted, and any pop in that cycle is ignored. bjp_i_ready may still be 1 during flush; the handshake is still considered discarded.
- Head data stays stable while bjp_o_valid=1 and bjp_o_ready=0.
- Operand bits are not stored; each entry holds {prdt, rslv, illegal, tag}.

Optional Feature:
QPU_BJP_PERF_CNT_EN defined:
- Adds outputs bjp_o_cnt_br [CNT_W] (popped entries) and bjp_o_cnt_mis [CNT_W] (popped entries with mispred=1).
- Both counters saturate at all-ones, reset to 0, and are not cleared by flush.
Undefined: no counter ports or registers exist.

Decomposition:
- Shared package/defines: op encoding constants (BJP_OP_EQ..LE, width 3), result entry field offsets, default XLEN.
- One natural sub-module: qpu_bjp_res_fifo, a generic DEPTH×W synchronous FIFO with flush, pointers, count, full and empty. The comparator stays inline in the top level.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles → bjp_o_valid=0, bjp_i_ready=1, all outputs 0.
- Signed vs unsigned: rs1=0xFFFFFFFF, rs2=1, op=LT, bprdt=0, unsigned=0 → rslv=1, mispred=1. Same with unsigned=1 → rslv=0, mispred=0.
- Back-to-back throughput: 8 branches (tags 0–7), DEPTH=2, bjp_o_ready=1 continuously → one result per cycle from cycle N+1, tags in order 0–7.
- Backpressure/full: bjp_o_ready=0, push 3 → first 2 accepted, bjp_i_ready=0 on the 3rd. Hold 5 cycles → head tag stable. Release → 2 pops, then the 3rd is accepted.
- Flush: queue holds 2 entries, assert flush together with a valid input → next cycle bjp_o_valid=0 and the input is not visible later.
- Perf (macro on, CNT_W=2): pop 5 branches, 4 of them mispredicted → cnt_br=3, cnt_mis=3 (saturated). A following flush leaves both unchanged.
